// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus responder.
package cpu_bus_pkg;

  localparam int CPU_AW = 8;
  localparam int CPU_DW = 8;

  // Value returned on a read that misses the register window.
  localparam logic [CPU_DW-1:0] RD_MISS_VALUE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_bus_regbank.sv
// Byte register storage: one write port, one read mux, flat export of all registers.
module cpu_bus_regbank #(
  parameter int DW    = 8,
  parameter int NREGS = 16,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [IW-1:0]       idx,
  input  logic [DW-1:0]       d,
  output logic [DW-1:0]       q,
  output logic [NREGS*DW-1:0] reg_q
);

  logic [DW-1:0] regs [NREGS];

  // Register array: cleared on reset, single write per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[idx] <= d;
    end
  end

  assign q = regs[idx];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign reg_q[g*DW +: DW] = regs[g];
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Target end of the 8-bit CPU bus: decodes a register window, inserts wait
// states, performs exactly one access per ce assertion and pulses ack/err.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int             AW          = CPU_AW,
  parameter int             DW          = CPU_DW,
  parameter int             NREGS       = 16,
  parameter logic [AW-1:0]  BASE_ADDR   = 'h10,
  parameter int             WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                rd,
  input  logic                wr,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       data_wr,
  output logic [DW-1:0]       data_rd,
  output logic                ack,
  output logic                err,
  output logic [NREGS*DW-1:0] reg_q
);

  localparam int IW = $clog2(NREGS);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          access;
  logic          req;

  logic [AW-1:0] addr_cap;
  logic [DW-1:0] data_cap;
  logic          rd_cap, wr_cap;

  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_data;
  logic          eff_rd, eff_wr;
  logic          hit;
  logic [IW-1:0] idx;
  logic          we;
  logic [DW-1:0] rdata;

  assign req = ce & (rd | wr);

  // In IDLE the access (zero wait states) uses the live bus; otherwise the captured request.
  assign eff_addr = (state == IDLE) ? addr    : addr_cap;
  assign eff_data = (state == IDLE) ? data_wr : data_cap;
  assign eff_rd   = (state == IDLE) ? rd      : rd_cap;
  assign eff_wr   = (state == IDLE) ? wr      : wr_cap;

  // Window is aligned to NREGS, so a hit is a match on the upper address bits.
  assign hit = (eff_addr[AW-1:IW] == BASE_ADDR[AW-1:IW]);
  assign idx = eff_addr[IW-1:0];
  assign we  = access & hit & eff_wr & ~eff_rd;

  cpu_bus_regbank #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regbank (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .idx   (idx),
    .d     (eff_data),
    .q     (rdata),
    .reg_q (reg_q)
  );

  // Request capture; only IDLE accepts, later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_cap <= addr;
      data_cap <= data_wr;
      rd_cap   <= rd;
      wr_cap   <= wr;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and the single-cycle access strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            access    = 1'b1;
            state_nxt = ACK;
          end else begin
            cnt_nxt   = 4'(WAIT_STATES);
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!ce) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == 4'd1) begin
          cnt_nxt   = '0;
          access    = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK:     state_nxt = ce ? HOLD : IDLE;
      HOLD:    if (!ce) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Completion outputs: ack/err pulse for the cycle after the access; read data held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack     <= 1'b0;
      err     <= 1'b0;
      data_rd <= '0;
    end else begin
      ack <= access;
      err <= access & (~hit | (eff_rd & eff_wr));
      if (access && eff_rd && !eff_wr)
        data_rd <= hit ? rdata : {DW{RD_MISS_VALUE[0]}};
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: one WAIT_STATES=1 and one WAIT_STATES=0 instance
// driven by the same directed bus traffic and compared against a behavioural model.
module tb_cpu_bus_responder;

  localparam int         NREGS = 16;
  localparam logic [7:0] BASE  = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0, data_wr = '0;

  logic [7:0]   data_rd1, data_rd0;
  logic         ack1, err1, ack0, err0;
  logic [127:0] reg_q1, reg_q0;

  cpu_bus_responder #(.AW(8), .DW(8), .NREGS(NREGS), .BASE_ADDR(BASE), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .rd(rd), .wr(wr), .addr(addr), .data_wr(data_wr),
    .data_rd(data_rd1), .ack(ack1), .err(err1), .reg_q(reg_q1));

  cpu_bus_responder #(.AW(8), .DW(8), .NREGS(NREGS), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset(reset), .ce(ce), .rd(rd), .wr(wr), .addr(addr), .data_wr(data_wr),
    .data_rd(data_rd0), .ack(ack0), .err(err0), .reg_q(reg_q0));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: W=1, index 1: W=0) ----------------
  int       mw [2] = '{1, 0};
  bit [7:0] m_mem  [2][NREGS];
  bit [7:0] m_rd   [2];
  bit       m_ackc [2];
  bit       m_err  [2];
  bit       m_pend [2];
  bit       m_lock [2];
  int       m_left [2];
  bit [7:0] c_addr [2], c_data [2];
  bit       c_rd [2], c_wr [2];

  function automatic void m_access(int k, bit [7:0] a, bit [7:0] d, bit r, bit w);
    bit hitm = (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + NREGS);
    int i    = int'(a) - int'(BASE);
    m_ackc[k] = 1'b1;
    if (r && w) begin
      m_err[k] = 1'b1;
    end else if (!hitm) begin
      m_err[k] = 1'b1;
      if (r) m_rd[k] = 8'hFF;
    end else begin
      m_err[k] = 1'b0;
      if (w) m_mem[k][i] = d;
      else   m_rd[k] = m_mem[k][i];
    end
  endfunction

  function automatic bit [127:0] m_flat(int k);
    bit [127:0] f = '0;
    for (int i = 0; i < NREGS; i++) f[i*8 +: 8] = m_mem[k][i];
    return f;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NREGS; i++) m_mem[k][i] = '0;
        m_rd[k] = '0; m_ackc[k] = 0; m_err[k] = 0;
        m_pend[k] = 0; m_lock[k] = 0; m_left[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_ackc[k]) begin
          m_ackc[k] = 0;
          m_err[k]  = 0;
          m_lock[k] = ce;
        end else if (m_lock[k]) begin
          if (!ce) m_lock[k] = 0;
        end else if (m_pend[k]) begin
          if (!ce) m_pend[k] = 0;
          else if (m_left[k] == 1) begin
            m_pend[k] = 0;
            m_access(k, c_addr[k], c_data[k], c_rd[k], c_wr[k]);
          end else m_left[k]--;
        end else if (ce && (rd || wr)) begin
          c_addr[k] = addr; c_data[k] = data_wr; c_rd[k] = rd; c_wr[k] = wr;
          if (mw[k] == 0) m_access(k, addr, data_wr, rd, wr);
          else begin
            m_pend[k] = 1;
            m_left[k] = mw[k];
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("w1_ack",   ack1,     m_ackc[0]);
      chk("w1_err",   err1,     m_err[0]);
      chk("w1_rdata", data_rd1, m_rd[0]);
      chk("w1_regq",  reg_q1,   m_flat(0));
      chk("w0_ack",   ack0,     m_ackc[1]);
      chk("w0_err",   err0,     m_err[1]);
      chk("w0_rdata", data_rd0, m_rd[1]);
      chk("w0_regq",  reg_q0,   m_flat(1));
    end
  end

  // ---------------- directed stimulus ----------------
  int         cyc;
  bit         a0f;
  logic [7:0] drd;
  logic       e;
  int         nack;
  logic [127:0] expq;

  task automatic bus(input logic [7:0] a, input bit r, input bit w, input logic [7:0] d,
                     output int c, output bit a0first, output logic [7:0] dr, output logic er);
    ce = 1'b1; rd = r; wr = w; addr = a; data_wr = d;
    c = 0; a0first = 0; dr = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) a0first = ack0;
      if (ack1) begin
        c = i; dr = data_rd1; er = err1;
        break;
      end
    end
    if (c == 0) begin
      total++; bad++;
      $display("FAIL bus_timeout: no ack for addr %h within 20 cycles", a);
    end
    ce = 1'b0; rd = 1'b0; wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack",   ack1,     1'b0);
    chk("rst_err",   err1,     1'b0);
    chk("rst_rdata", data_rd1, 8'h00);
    chk("rst_regq",  reg_q1,   128'h0);
    checking = 1'b1;
    reset = 1'b1;
    @(negedge clk);

    // 1: write then read back; ack two cycles after drive (E0+1), W=0 acks one cycle after.
    bus(8'h11, 0, 1, 8'hAA, cyc, a0f, drd, e);
    chk("t1_wr_lat", cyc, 2); chk("t1_w0_lat", a0f, 1'b1); chk("t1_wr_err", e, 1'b0);
    bus(8'h11, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t1_rd_lat", cyc, 2); chk("t1_rd_data", drd, 8'hAA); chk("t1_rd_err", e, 1'b0);

    // 2: two more registers
    bus(8'h12, 0, 1, 8'hAB, cyc, a0f, drd, e);
    bus(8'h13, 0, 1, 8'h0A, cyc, a0f, drd, e);
    bus(8'h12, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t2_rd12", drd, 8'hAB);
    bus(8'h13, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t2_rd13", drd, 8'h0A);
    chk("t2_q2", reg_q1[2*8 +: 8], 8'hAB);
    chk("t2_q3", reg_q1[3*8 +: 8], 8'h0A);

    // 3: decode misses
    bus(8'h05, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t3_rdmiss_err", e, 1'b1); chk("t3_rdmiss_data", drd, 8'hFF);
    bus(8'h30, 0, 1, 8'h55, cyc, a0f, drd, e);
    chk("t3_wrmiss_err", e, 1'b1);
    expq = '0; expq[1*8 +: 8] = 8'hAA; expq[2*8 +: 8] = 8'hAB; expq[3*8 +: 8] = 8'h0A;
    chk("t3_regq", reg_q1, expq);

    // 4: rd and wr together
    bus(8'h11, 1, 1, 8'h33, cyc, a0f, drd, e);
    chk("t4_err", e, 1'b1); chk("t4_data_held", drd, 8'hFF); chk("t4_reg1", reg_q1[1*8 +: 8], 8'hAA);

    // window edges
    bus(8'h1F, 0, 1, 8'h5A, cyc, a0f, drd, e);
    chk("edge_wr1f_err", e, 1'b0);
    bus(8'h1F, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("edge_rd1f", drd, 8'h5A);
    bus(8'h10, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("edge_rd10", drd, 8'h00); chk("edge_rd10_err", e, 1'b0);
    bus(8'h20, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("edge_rd20_err", e, 1'b1); chk("edge_rd20", drd, 8'hFF);
    bus(8'h0F, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("edge_rd0f_err", e, 1'b1);

    // 5a: ce dropped during WAIT aborts the write
    ce = 1; wr = 1; addr = 8'h14; data_wr = 8'h77;
    @(negedge clk);
    ce = 0; wr = 0;
    nack = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (ack1) nack++; end
    chk("t5_abort_ack", nack, 0);
    chk("t5_abort_reg", reg_q1[4*8 +: 8], 8'h00);

    // 5b: ce held for five cycles gives one ack
    ce = 1; rd = 1; addr = 8'h11;
    nack = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (ack1) nack++; end
    chk("t5_hold_acks", nack, 1);
    ce = 0; rd = 0;
    @(negedge clk);
    bus(8'h12, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t5_after_lat", cyc, 2); chk("t5_after_data", drd, 8'hAB);

    // 6: asynchronous reset while waiting
    ce = 1; wr = 1; addr = 8'h15; data_wr = 8'h99;
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("t6_ack", ack1, 1'b0);
    chk("t6_regq", reg_q1, 128'h0);
    chk("t6_w0_regq", reg_q0, 128'h0);
    @(negedge clk);
    ce = 0; wr = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    bus(8'h15, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t6_rd15", drd, 8'h00); chk("t6_lat", cyc, 2); chk("t6_w0_lat", a0f, 1'b1);
    bus(8'h11, 1, 0, 8'h00, cyc, a0f, drd, e);
    chk("t6_rd11", drd, 8'h00);

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
